select_rr_n: RTL

Parametrised N-channel, WIDTH-bit registered select stage with per-channel valid/ready handshake. It extends the datapath's plain 2:1 select in three ways: any channel count, a fixed-select mode and a round-robin mode, and a one-entry registered output. It sits between multiple producers (e.g. writeback sources, bus masters) and a single consumer in the multi-cycle/pipelined CPU datapath.

---
 rtl/select_rr_n_pkg.sv | 11 +
 rtl/select_rr_n_if.sv | 31 +++
 rtl/select_rr_n_rr_arbiter.sv | 32 +++
 rtl/select_rr_n.sv | 81 ++++++++
 4 files changed

// File: rtl/select_rr_n_pkg.sv
// select_rr_n shared types: default sizes and mode encodings.
// Imported by the interface, the arbiter and the select stage.
package select_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int NUM_CH_DEF = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/select_rr_n_if.sv
// select_rr_n bus: per-channel valid/ready/data in, one registered word out.
// master = producers+consumer side, slave = the select stage.
interface select_rr_n_if
  import select_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = $clog2(NUM_CH)
) ();

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/select_rr_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// In: req, ptr. Out: one-hot gnt and its encoded idx.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Scan ptr, ptr+1, ... with explicit modulo so any NUM_CH works.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = SEL_W'((int'(ptr) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/select_rr_n.sv
// select_rr_n: N-channel fixed/round-robin select into a one-word register.
// Ports: clk, rst (async high), bus (select_rr_n_if.slave).
module select_rr_n
  import select_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic         clk,
  input  logic         rst,
  select_rr_n_if.slave bus
);

  logic [SEL_W-1:0]  ptr;
  logic              load;
  logic              any;
  logic [NUM_CH-1:0] fgnt;
  logic [NUM_CH-1:0] rgnt;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  ridx;
  logic [SEL_W-1:0]  gidx;
  logic [WIDTH-1:0]  gdata;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (rgnt),
    .idx (ridx)
  );

  // Out-of-range sel grants nothing.
  always_comb begin
    fgnt = '0;
    if (int'(bus.sel) < NUM_CH)
      fgnt[bus.sel] = bus.in_valid[bus.sel];
  end

  always_comb begin
    gnt  = fgnt;
    gidx = bus.sel;
    if (bus.mode == MODE_RR) begin
      gnt  = rgnt;
      gidx = ridx;
    end
  end

  assign load  = !bus.out_valid || bus.out_ready;
  assign any   = |gnt;
  assign gdata = bus.in_data[gidx*WIDTH +: WIDTH];

  // Gated by rst so nothing is accepted while reset is held.
  assign bus.in_ready = (load && !rst) ? gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (load) begin
      if (any) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= gdata;
        bus.out_ch    <= gidx;
        if (bus.mode == MODE_RR) begin
          if (gidx == SEL_W'(NUM_CH - 1))
            ptr <= '0;
          else
            ptr <= gidx + 1'b1;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
